// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the MIPS pipeline
//
// Purpose: word width, bubble instruction, default reset PC, fetch FSM
// state encoding and the IF/ID bundle shared by if_stage and if_pc_reg.
// Ports: none (package).
package pipe_pkg;

  localparam int XLEN = 32;

  // sll $0,$0,0 encodes as all zeros
  localparam logic [XLEN-1:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    NORMAL  = 1'b0,
    DS_PEND = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } ifid_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_pc_reg.sv
// rtl/if_pc_reg.sv - program counter register with +4 incrementer and next-PC mux
//
// Purpose: holds the fetch PC. Load (redirect or saved target) has priority
// over increment; with neither asserted the PC holds.
// Ports:
//   clk          in   core clock
//   rst          in   synchronous active-high reset
//   i_load       in   load i_load_addr (low two bits forced to 00)
//   i_load_addr  in   load address
//   i_inc        in   advance PC by 4
//   o_pc         out  current PC
//   o_pc4        out  current PC + 4 (32-bit modulo)
module if_pc_reg
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_load_addr,
  input  logic            i_inc,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc4
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc4;

  // Natural wrap: 0xFFFF_FFFC + 4 = 0x0000_0000
  assign w_pc4 = r_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= word_align(RESET_PC);
    end else if (i_load) begin
      r_pc <= word_align(i_load_addr);
    end else if (i_inc) begin
      r_pc <= w_pc4;
    end
  end

  assign o_pc  = r_pc;
  assign o_pc4 = w_pc4;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage with IF/ID pipeline register
//
// Purpose: drives the instruction-memory request from the PC and captures
// each fetched word with its PC+4 into the IF/ID register. Stall holds PC
// and IF/ID; redirect reloads the PC. Build option MIPS_DELAY_SLOT_EN adds
// an architectural branch delay slot (NORMAL/DS_PEND FSM + saved target).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req/imem_addr        fetch request (= ~rst) and current PC
//   imem_rdata/imem_ready     returned word and its valid strobe
//   stall                     hold PC and IF/ID
//   redirect/redirect_target  taken branch/jump and its target
//   ifid_instr/pc4/valid      registered instruction bundle to ID
module if_stage
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] ifid_instr,
  output logic [XLEN-1:0] ifid_pc4,
  output logic            ifid_valid
);

  logic            w_fire;
  logic            w_pc_load;
  logic            w_pc_inc;
  logic [XLEN-1:0] w_pc_load_addr;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_pc4;
  ifid_t           r_ifid;

  assign w_fire = imem_ready & ~stall;

  if_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_pc_load),
    .i_load_addr (w_pc_load_addr),
    .i_inc       (w_pc_inc),
    .o_pc        (w_pc),
    .o_pc4       (w_pc4)
  );

`ifdef MIPS_DELAY_SLOT_EN

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_saved_target;

  // The word at the current PC is the delay slot; the PC only jumps once
  // that word has actually been fetched. In DS_PEND new redirects are ignored.
  assign w_pc_load      = w_fire & ((redirect & (r_state == NORMAL)) | (r_state == DS_PEND));
  assign w_pc_load_addr = (r_state == DS_PEND) ? r_saved_target : redirect_target;
  assign w_pc_inc       = w_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= NORMAL;
      r_saved_target <= '0;
      r_ifid         <= '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};
    end else begin
      case (r_state)
        NORMAL: begin
          if (redirect && !w_fire) begin
            r_saved_target <= word_align(redirect_target);
            r_state        <= DS_PEND;
          end
        end
        DS_PEND: begin
          if (w_fire) begin
            r_state <= NORMAL;
          end
        end
        default: r_state <= NORMAL;
      endcase

      // Redirect never squashes here: the delay-slot word must reach ID
      if (stall) begin
        r_ifid <= r_ifid;
      end else if (imem_ready) begin
        r_ifid <= '{instr: imem_rdata, pc4: w_pc4, valid: 1'b1};
      end else begin
        r_ifid <= '{instr: NOP_INSTR, pc4: r_ifid.pc4, valid: 1'b0};
      end
    end
  end

`else

  // Redirect reloads the PC even during a stall and squashes the IF slot
  assign w_pc_load      = redirect;
  assign w_pc_load_addr = redirect_target;
  assign w_pc_inc       = w_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifid <= '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};
    end else if (redirect) begin
      r_ifid <= '{instr: NOP_INSTR, pc4: r_ifid.pc4, valid: 1'b0};
    end else if (stall) begin
      r_ifid <= r_ifid;
    end else if (imem_ready) begin
      r_ifid <= '{instr: imem_rdata, pc4: w_pc4, valid: 1'b1};
    end else begin
      r_ifid <= '{instr: NOP_INSTR, pc4: r_ifid.pc4, valid: 1'b0};
    end
  end

`endif

  assign imem_req   = ~rst;
  assign imem_addr  = w_pc;
  assign ifid_instr = r_ifid.instr;
  assign ifid_pc4   = r_ifid.pc4;
  assign ifid_valid = r_ifid.valid;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural PC, IF/ID contents and pending delay slot
  logic [31:0] m_pc, m_instr, m_pc4, m_tgt;
  logic        m_valid, m_pend;

  always #5 clk = ~clk;

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .ifid_instr      (ifid_instr),
    .ifid_pc4        (ifid_pc4),
    .ifid_valid      (ifid_valid)
  );

  // Apply one cycle of inputs, advance the model by the same rules, and
  // return 1 ns after the edge so outputs are sampled away from it.
  task automatic step(input logic r, input logic rdy, input logic st, input logic rd,
                      input logic [31:0] data, input logic [31:0] tgt);
    rst = r; imem_ready = rdy; stall = st; redirect = rd;
    imem_rdata = data; redirect_target = tgt;
    if (r) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_pend = 1'b0; m_tgt = 32'h0;
    end else begin
`ifdef MIPS_DELAY_SLOT_EN
      if (st) begin
        if (rd && !m_pend) begin m_pend = 1'b1; m_tgt = tgt & ~32'h3; end
      end else if (rdy) begin
        m_instr = data; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        if (m_pend) m_pc = m_tgt;
        else if (rd) m_pc = tgt & ~32'h3;
        else m_pc = m_pc + 32'd4;
        m_pend = 1'b0;
      end else begin
        m_instr = 32'h0; m_valid = 1'b0;
        if (rd && !m_pend) begin m_pend = 1'b1; m_tgt = tgt & ~32'h3; end
      end
`else
      if (rd) begin
        m_pc = tgt & ~32'h3; m_instr = 32'h0; m_valid = 1'b0;
      end else if (!st) begin
        if (rdy) begin
          m_instr = data; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
        end else begin
          m_instr = 32'h0; m_valid = 1'b0;
        end
      end
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h2008_0001, 32'h0);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ifid_valid); end
    checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 00000000", ifid_instr); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h2008_0001, 32'h0);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", imem_req); end
    checks++; if (ifid_instr !== 32'h2008_0001) begin errors++; $display("FAIL first_instr: got %h expected 20080001", ifid_instr); end
    checks++; if (ifid_pc4 !== 32'h4) begin errors++; $display("FAIL first_pc4: got %h expected 00000004", ifid_pc4); end
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL first_addr: got %h expected 00000004", imem_addr); end
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b expected 1", ifid_valid); end
  endtask

  task automatic test_stall();
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'hA000_0004, 32'h0);
    checks++; if (ifid_instr !== 32'hA000_0004) begin errors++; $display("FAIL stream_instr: got %h expected a0000004", ifid_instr); end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'hA000_0008, 32'h0);
      checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stall_addr[%0d]: got %h expected 00000008", i, imem_addr); end
      checks++; if (ifid_instr !== 32'hA000_0004) begin errors++; $display("FAIL stall_instr[%0d]: got %h expected a0000004", i, ifid_instr); end
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, ifid_valid); end
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'hA000_0008, 32'h0);
    checks++; if (ifid_instr !== 32'hA000_0008) begin errors++; $display("FAIL unstall_instr: got %h expected a0000008", ifid_instr); end
    checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL unstall_addr: got %h expected 0000000c", imem_addr); end
  endtask

  task automatic test_wait();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid[%0d]: got %b expected 0", i, ifid_valid); end
      checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL bubble_instr[%0d]: got %h expected 00000000", i, ifid_instr); end
      checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL bubble_addr[%0d]: got %h expected 0000000c", i, imem_addr); end
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'hA000_000C, 32'h0);
    checks++; if (ifid_pc4 !== 32'h10) begin errors++; $display("FAIL resume_pc4: got %h expected 00000010", ifid_pc4); end
    checks++; if (ifid_instr !== 32'hA000_000C) begin errors++; $display("FAIL resume_instr: got %h expected a000000c", ifid_instr); end
  endtask

  task automatic test_redirect();
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'hA000_0010, 32'h43);
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL redir_addr: got %h expected 00000040", imem_addr); end
`ifdef MIPS_DELAY_SLOT_EN
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL redir_ds_valid: got %b expected 1", ifid_valid); end
    checks++; if (ifid_instr !== 32'hA000_0010) begin errors++; $display("FAIL redir_ds_instr: got %h expected a0000010", ifid_instr); end
`else
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b expected 0", ifid_valid); end
    checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL redir_instr: got %h expected 00000000", ifid_instr); end
`endif
  endtask

`ifdef MIPS_DELAY_SLOT_EN
  task automatic test_delay_slot_pending();
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'hA000_0040, 32'h20);
    checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL ds_setup_addr: got %h expected 00000020", imem_addr); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h80);
    checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL ds_pend_addr0: got %h expected 00000020", imem_addr); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL ds_pend_valid: got %b expected 0", ifid_valid); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h100);
    checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL ds_pend_addr1: got %h expected 00000020", imem_addr); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'hA000_0020, 32'h0);
    checks++; if (ifid_instr !== 32'hA000_0020) begin errors++; $display("FAIL ds_fire_instr: got %h expected a0000020", ifid_instr); end
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL ds_fire_valid: got %b expected 1", ifid_valid); end
    checks++; if (imem_addr !== 32'h80) begin errors++; $display("FAIL ds_fire_addr: got %h expected 00000080", imem_addr); end
  endtask
`endif

  task automatic test_wrap();
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF);
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target: got %h expected fffffffc", imem_addr); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h3C00_0001, 32'h0);
    checks++; if (ifid_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h expected 00000000", ifid_pc4); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 00000000", imem_addr); end
    checks++; if (ifid_instr !== 32'h3C00_0001) begin errors++; $display("FAIL wrap_instr: got %h expected 3c000001", ifid_instr); end
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h202);
`ifdef MIPS_DELAY_SLOT_EN
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL stall_redir_hold: got %h expected 00000000", imem_addr); end
    checks++; if (ifid_instr !== 32'h3C00_0001) begin errors++; $display("FAIL stall_redir_ifid: got %h expected 3c000001", ifid_instr); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h1111_1111, 32'h0);
    checks++; if (ifid_instr !== 32'h1111_1111) begin errors++; $display("FAIL stall_redir_ds: got %h expected 11111111", ifid_instr); end
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL stall_redir_addr: got %h expected 00000200", imem_addr); end
`else
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL stall_redir_addr: got %h expected 00000200", imem_addr); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL stall_redir_valid: got %b expected 0", ifid_valid); end
`endif
  endtask

  task automatic test_random();
    logic r, rdy, st, rd;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 4) == 0);
      rd  = ($urandom_range(0, 6) == 0);
      step(r, rdy, st, rd, $urandom, $urandom);
      checks++; if (imem_req !== !r) begin errors++; $display("FAIL rnd_req[%0d]: got %b expected %b", i, imem_req, !r); end
      checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr[%0d]: got %h expected %h", i, imem_addr, m_pc); end
      checks++; if (ifid_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, ifid_valid, m_valid); end
      checks++; if (ifid_instr !== m_instr) begin errors++; $display("FAIL rnd_instr[%0d]: got %h expected %h", i, ifid_instr, m_instr); end
      checks++; if (m_valid && ifid_pc4 !== m_pc4) begin errors++; $display("FAIL rnd_pc4[%0d]: got %h expected %h", i, ifid_pc4, m_pc4); end
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_wait();
    test_redirect();
`ifdef MIPS_DELAY_SLOT_EN
    test_delay_slot_pending();
`endif
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
